// File: rtl/ring_freq_meter_pkg.sv
// Shared definitions for the ring-oscillator frequency meter: state encoding
// and default widths.
package ring_freq_meter_pkg;

  localparam int GATE_W_DEF = 16;
  localparam int CNT_W_DEF  = 16;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GATE = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/ring_freq_meter_osc_sync_edge.sv
// Two-flop synchronizer plus history flop for the divided ring clock; rise is
// a one-cycle pulse per synchronized rising edge.
module osc_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/ring_freq_meter.sv
// Gated edge counter for the pre-divided ring oscillator, with a held parallel
// result and an MSB-first serial readout register.
module ring_freq_meter
  import ring_freq_meter_pkg::*;
#(
  parameter int GATE_W = GATE_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              osc_in,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  input  logic              shift_en,
  output logic              ser_out
);

  logic [1:0]        state_reg;
  logic [1:0]        state_next;
  logic [GATE_W-1:0] gate_cnt_reg;
  logic [CNT_W-1:0]  acc_reg;
  logic              ovf_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              overflow_reg;
  logic [CNT_W-1:0]  shreg_reg;
  logic              rise;

  osc_sync_edge u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (osc_in),
    .rise     (rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = (gate_len == '0) ? DONE : GATE;
      GATE: if (gate_cnt_reg == GATE_W'(1)) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == GATE) || (state_reg == DONE);
    done = (state_reg == DONE);
  end

  // Gate counter and saturating accumulator; a rise at all-ones is a lost edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt_reg <= '0;
      acc_reg      <= '0;
      ovf_reg      <= 1'b0;
    end else if (state_reg == IDLE) begin
      if (start) begin
        gate_cnt_reg <= gate_len;
        acc_reg      <= '0;
        ovf_reg      <= 1'b0;
      end
    end else if (state_reg == GATE) begin
      gate_cnt_reg <= gate_cnt_reg - GATE_W'(1);
      if (rise) begin
        if (&acc_reg) ovf_reg <= 1'b1;
        else          acc_reg <= acc_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (state_reg == DONE) begin
      count_reg    <= acc_reg;
      overflow_reg <= ovf_reg;
    end
  end

  // A fresh result overrides any shift requested in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 shreg_reg <= '0;
    else if (state_reg == DONE) shreg_reg <= acc_reg;
    else if (shift_en)          shreg_reg <= {shreg_reg[CNT_W-2:0], 1'b0};
  end

  assign count    = count_reg;
  assign overflow = overflow_reg;
  assign ser_out  = shreg_reg[CNT_W-1];

endmodule

// File: tb/tb_ring_freq_meter.sv
// Bench for ring_freq_meter: a 16-bit and a 4-bit instance share stimulus and
// are compared every cycle against a window/edge-count model.
`timescale 1ns/1ps
module tb_ring_freq_meter;

  localparam int GW  = 16;
  localparam int CW  = 16;
  localparam int CW4 = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          osc_in = 1'b0;
  logic          start = 1'b0;
  logic          shift_en = 1'b0;
  logic [GW-1:0] gate_len = '0;

  logic          busy_a, done_a, ovf_a, ser_a;
  logic [CW-1:0] count_a;
  logic          busy_b, done_b, ovf_b, ser_b;
  logic [CW4-1:0] count_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  ring_freq_meter dut_a (
    .clk(clk), .rst_n(rst_n), .osc_in(osc_in), .start(start), .gate_len(gate_len),
    .busy(busy_a), .done(done_a), .count(count_a), .overflow(ovf_a),
    .shift_en(shift_en), .ser_out(ser_a)
  );

  ring_freq_meter #(.GATE_W(GW), .CNT_W(CW4)) dut_b (
    .clk(clk), .rst_n(rst_n), .osc_in(osc_in), .start(start), .gate_len(gate_len),
    .busy(busy_b), .done(done_b), .count(count_b), .overflow(ovf_b),
    .shift_en(shift_en), .ser_out(ser_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Oscillator generator: 0 = low, 1 = fixed half-period, 2 = random phases, 3 = follow osc_req
  int   osc_mode = 3;
  int   half = 4;
  int   phase = 0;
  logic osc_req = 1'b0;

  initial forever begin
    @(posedge clk);
    #2;
    case (osc_mode)
      0: begin osc_in = 1'b0; phase = 0; end
      1: begin
        phase++;
        if (phase >= half) begin phase = 0; osc_in = ~osc_in; end
      end
      2: begin
        if (phase <= 1) begin osc_in = ~osc_in; phase = $urandom_range(2, 7); end
        else phase--;
      end
      default: osc_in = osc_req;
    endcase
  end

  // Reference model: a measurement accepted in cycle t spans cycles t+1..t+gl,
  // done lands in t+gl+1, and an osc rise launched in cycle k counts in cycle k+2.
  bit osc_hist [0:65535];

  function automatic int edges(input int a, input int b);
    int n = 0;
    for (int c = a; c <= b; c++)
      if (c >= 3 && osc_hist[c-2] && !osc_hist[c-3]) n++;
    return n;
  endfunction

  initial begin
    int m_act = 0, m_t = 0, m_gl = 0, m_d = 0, shifts = 0, e = 0;
    logic [CW-1:0]  ec16 = '0;
    logic [CW4-1:0] ec4 = '0;
    logic eo16 = 1'b0, eo4 = 1'b0, in_meas, exp_done, es16, es4;
    forever begin
      @(negedge clk);
      osc_hist[cyc] = osc_in;
      if (!rst_n) begin
        m_act = 0; shifts = CW; ec16 = '0; ec4 = '0; eo16 = 1'b0; eo4 = 1'b0;
        in_meas = 1'b0; exp_done = 1'b0;
      end else begin
        in_meas  = (m_act != 0) && cyc > m_t && cyc <= m_d;
        exp_done = (m_act != 0) && cyc == m_d;
      end
      es16 = (shifts < CW)  ? ec16[CW-1-shifts]  : 1'b0;
      es4  = (shifts < CW4) ? ec4[CW4-1-shifts]  : 1'b0;
      chk("busy16",  busy_a,  in_meas);
      chk("done16",  done_a,  exp_done);
      chk("count16", count_a, ec16);
      chk("ovf16",   ovf_a,   eo16);
      chk("ser16",   ser_a,   es16);
      chk("busy4",   busy_b,  in_meas);
      chk("done4",   done_b,  exp_done);
      chk("count4",  count_b, ec4);
      chk("ovf4",    ovf_b,   eo4);
      chk("ser4",    ser_b,   es4);
      if (rst_n) begin
        if (exp_done) begin
          e = edges(m_t + 1, m_t + m_gl);
          ec16 = (e > 65535) ? 16'hFFFF : CW'(e);
          eo16 = (e > 65535);
          ec4  = (e > 15) ? 4'hF : CW4'(e);
          eo4  = (e > 15);
          shifts = 0;
          m_act = 0;
        end else if (shift_en && shifts < 64) begin
          shifts++;
        end
        if (!in_meas && start) begin
          m_act = 1; m_t = cyc; m_gl = int'(gate_len); m_d = cyc + int'(gate_len) + 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int gl, output int t);
    start = 1'b1;
    gate_len = GW'(gl);
    t = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done_a === 1'b1) begin dc = cyc; break; end
    end
    if (dc < 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int t, d, n;
    logic [15:0] word;

    // Reset with random inputs
    repeat (3) begin
      tick();
      start = 1'($urandom); shift_en = 1'($urandom); gate_len = GW'($urandom);
      osc_req = 1'($urandom);
    end
    @(negedge clk);
    chk("rst_busy", busy_a, 0); chk("rst_done", done_a, 0); chk("rst_count", count_a, 0);
    chk("rst_ovf", ovf_a, 0); chk("rst_ser", ser_a, 0);
    tick();
    rst_n = 1'b1; start = 1'b0; shift_en = 1'b0; gate_len = '0; osc_mode = 0;
    repeat (6) tick();

    // Nominal: period 8, window 80
    osc_mode = 1; half = 4;
    repeat (5) tick();
    pulse_start(80, t);
    wait_done(d);
    chk("nom_latency", d - t, 81);
    tick();
    @(negedge clk);
    chk("nom_count", count_a, 10); chk("nom_ovf", ovf_a, 0);
    chk("nom_busy_after", busy_a, 0); chk("nom_count4", count_b, 10);
    tick();

    // Serial readout of 0x000A
    word = '0;
    repeat (16) begin
      shift_en = 1'b1;
      @(negedge clk);
      word = {word[14:0], ser_a};
      tick();
    end
    shift_en = 1'b0;
    @(negedge clk);
    chk("ser_word", word, 16'h000A);
    chk("ser_empty", ser_a, 0);
    tick();

    // Zero-length gate
    osc_mode = 0;
    repeat (6) tick();
    pulse_start(0, t);
    wait_done(d);
    chk("zero_latency", d - t, 1);
    tick();
    @(negedge clk);
    chk("zero_count", count_a, 0);
    tick();

    // One-cycle gate with rise landing in t+1
    osc_req = 1'b1; osc_mode = 3;
    tick();
    pulse_start(1, t);
    wait_done(d);
    chk("one_latency", d - t, 2);
    tick();
    @(negedge clk);
    chk("one_count", count_a, 1);
    tick();
    osc_req = 1'b0;
    repeat (4) tick();

    // Saturation in the 4-bit instance
    osc_mode = 1; half = 2;
    repeat (4) tick();
    pulse_start(80, t);
    wait_done(d);
    tick();
    @(negedge clk);
    chk("sat_count4", count_b, 15); chk("sat_ovf4", ovf_b, 1);
    chk("sat_count16", count_a, 20); chk("sat_ovf16", ovf_a, 0);
    tick();
    pulse_start(40, t);
    wait_done(d);
    tick();
    @(negedge clk);
    chk("nosat_count4", count_b, 10); chk("nosat_ovf4", ovf_b, 0);
    tick();

    // Load wins over shift_en in DONE
    shift_en = 1'b1;
    pulse_start(40, t);
    wait_done(d);
    tick();
    @(negedge clk);
    chk("load_win_ser4", ser_b, 1);
    chk("load_win_ser16", ser_a, 0);
    tick();
    shift_en = 1'b0;

    // Second start while busy is ignored
    half = 4;
    pulse_start(80, t);
    repeat (29) tick();
    start = 1'b1; gate_len = GW'(5);
    tick();
    start = 1'b0;
    wait_done(d);
    chk("busy_latency", d - t, 81);
    tick();
    @(negedge clk);
    chk("busy_count", count_a, 10);
    n = 0;
    repeat (100) begin tick(); @(negedge clk); n += int'(done_a); end
    chk("busy_single_done", n, 0);
    tick();

    // Reset mid-GATE
    pulse_start(80, t);
    repeat (20) tick();
    rst_n = 1'b0; osc_mode = 0;
    @(negedge clk);
    chk("abort_busy", busy_a, 0); chk("abort_count", count_a, 0);
    tick(); tick();
    rst_n = 1'b1;
    n = 0;
    repeat (120) begin tick(); @(negedge clk); n += int'(done_a); end
    chk("abort_no_done", n, 0);
    tick();

    // Randomized run: random osc phases, starts, gate lengths and shifts
    osc_mode = 2;
    repeat (6000) begin
      start    = ($urandom_range(0, 19) == 0);
      gate_len = GW'($urandom_range(0, 150));
      shift_en = 1'($urandom);
      tick();
    end
    start = 1'b0; shift_en = 1'b0;
    repeat (200) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
